// File: rtl/falling_object_engine.sv
// Falling-object arcade engine: object pool, player paddle, tick-driven fall,
// collision-ended game FSM and a registered pixel-row readout.
module falling_object_engine #(
    parameter int N_OBJ    = 20,
    parameter int COLS     = 32,
    parameter int ROWS     = 16,
    parameter int PW       = 5,
    parameter int TICK_DIV = 250,
    parameter int COL_W    = $clog2(COLS),
    parameter int ROW_W    = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left_btn,
    input  logic             right_btn,
    input  logic             function_btn,
    input  logic             spawn_req,
    input  logic [COL_W-1:0] rand_col,
    input  logic [ROW_W-1:0] row_sel,
    output logic [COLS-1:0]  row_bits,
    output logic [COL_W-1:0] player_col,
    output logic [15:0]      score,
    output logic [1:0]       state
);

    localparam int TICK_W  = $clog2(TICK_DIV + 1);
    localparam int CW1     = COL_W + 1;
    localparam int FREED_W = $clog2(N_OBJ + 1);

    localparam logic [COL_W-1:0]  PLAYER_HOME = COL_W'((COLS - PW) / 2);
    localparam logic [COL_W-1:0]  PLAYER_MAX  = COL_W'(COLS - PW);
    localparam logic [COL_W-1:0]  COL_MAX     = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [CW1-1:0]    PW_SPAN     = CW1'(PW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                fn_prev_q;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [COL_W-1:0]    player_col_q, player_col_d;
    logic [15:0]         score_q, score_d;
    logic [N_OBJ-1:0]    valid_q, valid_d;
    logic [COL_W-1:0]    col_q [N_OBJ];
    logic [COL_W-1:0]    col_d [N_OBJ];
    logic [ROW_W-1:0]    y_q   [N_OBJ];
    logic [ROW_W-1:0]    y_d   [N_OBJ];
    logic [COLS-1:0]     row_bits_q, row_bits_d;

    logic                fn_rise_s;
    logic                collision_s;
    logic                tick_s;
    logic                start_game_s;
    logic                advance_s;
    logic [CW1-1:0]      span_hi_s;
    logic [COLS-1:0]     player_mask_s;
    logic [FREED_W-1:0]  freed_cnt_s;
    logic [16:0]         score_sum_s;
    logic                spawned_s;

    assign fn_rise_s = function_btn & ~fn_prev_q;
    assign span_hi_s = {1'b0, player_col_q} + PW_SPAN;

    // Collision detection and player sprite mask, from registered state only
    always_comb begin
        collision_s = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            collision_s = collision_s | (valid_q[i] && (y_q[i] == ROW_LAST) &&
                          ({1'b0, col_q[i]} >= {1'b0, player_col_q}) &&
                          ({1'b0, col_q[i]} <= span_hi_s));
        end
        for (int c = 0; c < COLS; c++) begin
            player_mask_s[c] = (CW1'(c) >= {1'b0, player_col_q}) && (CW1'(c) <= span_hi_s);
        end
    end

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fn_prev_q    <= 1'b0;
            tick_cnt_q   <= {TICK_W{1'b0}};
            player_col_q <= PLAYER_HOME;
            score_q      <= 16'd0;
            valid_q      <= {N_OBJ{1'b0}};
            row_bits_q   <= {COLS{1'b0}};
            for (int i = 0; i < N_OBJ; i++) begin
                col_q[i] <= {COL_W{1'b0}};
                y_q[i]   <= {ROW_W{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            fn_prev_q    <= function_btn;
            tick_cnt_q   <= tick_cnt_d;
            player_col_q <= player_col_d;
            score_q      <= score_d;
            valid_q      <= valid_d;
            row_bits_q   <= row_bits_d;
            col_q        <= col_d;
            y_q          <= y_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = fn_rise_s   ? S_PLAY : S_IDLE;
            S_PLAY:  state_d = collision_s ? S_OVER : S_PLAY;
            S_OVER:  state_d = fn_rise_s   ? S_IDLE : S_OVER;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-decoded control strobes; a colliding tick commits nothing
    always_comb begin
        tick_s       = (state_q == S_PLAY) && (tick_cnt_q == TICK_LAST);
        start_game_s = (state_q == S_IDLE) && fn_rise_s;
        advance_s    = tick_s && !collision_s;
    end

    // Game datapath: restart, tick counter, move / fall+score / spawn
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        player_col_d = player_col_q;
        score_d      = score_q;
        valid_d      = valid_q;
        col_d        = col_q;
        y_d          = y_q;
        freed_cnt_s  = {FREED_W{1'b0}};
        score_sum_s  = 17'd0;
        spawned_s    = 1'b0;
        if (start_game_s) begin
            valid_d      = {N_OBJ{1'b0}};
            score_d      = 16'd0;
            player_col_d = PLAYER_HOME;
            tick_cnt_d   = {TICK_W{1'b0}};
        end else if (state_q == S_PLAY) begin
            tick_cnt_d = tick_s ? {TICK_W{1'b0}} : tick_cnt_q + TICK_W'(1);
            if (advance_s) begin
                if (right_btn && !left_btn) begin
                    player_col_d = (player_col_q < PLAYER_MAX) ? player_col_q + COL_W'(1) : player_col_q;
                end else if (left_btn && !right_btn) begin
                    player_col_d = (player_col_q != {COL_W{1'b0}}) ? player_col_q - COL_W'(1) : player_col_q;
                end else begin
                    player_col_d = player_col_q;
                end
                for (int i = 0; i < N_OBJ; i++) begin
                    if (valid_q[i] && (y_q[i] == ROW_LAST)) begin
                        valid_d[i]  = 1'b0;
                        freed_cnt_s = freed_cnt_s + FREED_W'(1);
                    end else begin
                        y_d[i] = valid_q[i] ? y_q[i] + ROW_W'(1) : y_q[i];
                    end
                end
                score_sum_s = {1'b0, score_q} + 17'(freed_cnt_s);
                score_d     = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
                // Slots freed this tick are already eligible for the spawn
                for (int i = 0; i < N_OBJ; i++) begin
                    if (spawn_req && !spawned_s && !valid_d[i]) begin
                        valid_d[i] = 1'b1;
                        y_d[i]     = {ROW_W{1'b0}};
                        col_d[i]   = (rand_col > COL_MAX) ? COL_MAX : rand_col;
                        spawned_s  = 1'b1;
                    end else begin
                        spawned_s  = spawned_s;
                    end
                end
            end else begin
                player_col_d = player_col_q;
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Display row: all ones in IDLE, else objects on row_sel plus player on the last row
    always_comb begin
        row_bits_d = {COLS{1'b0}};
        if (state_q == S_IDLE) begin
            row_bits_d = {COLS{1'b1}};
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                row_bits_d[col_q[i]] = row_bits_d[col_q[i]] | (valid_q[i] && (y_q[i] == row_sel));
            end
            row_bits_d = row_bits_d | ((row_sel == ROW_LAST) ? player_mask_s : {COLS{1'b0}});
        end
    end

    assign row_bits   = row_bits_q;
    assign player_col = player_col_q;
    assign score      = score_q;
    assign state      = state_q;

endmodule

// File: tb/tb_falling_object_engine.sv
// Directed bench for falling_object_engine: default instance plus a ROWS=32,
// TICK_DIV=4 instance used for pool-exhaustion behaviour.
module tb_falling_object_engine;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, left_btn, right_btn, function_btn, spawn_req;
    logic [4:0]  rand_col;
    logic [3:0]  row_sel;
    logic [31:0] row_bits;
    logic [4:0]  player_col;
    logic [15:0] score;
    logic [1:0]  state;

    logic        rst2, fn2, spawn2;
    logic [4:0]  rand_col2;
    logic [4:0]  row_sel2;
    logic [31:0] row_bits2;
    logic [4:0]  player_col2;
    logic [15:0] score2;
    logic [1:0]  state2;

    falling_object_engine u_dut (
        .clk(clk), .rst(rst), .left_btn(left_btn), .right_btn(right_btn),
        .function_btn(function_btn), .spawn_req(spawn_req), .rand_col(rand_col),
        .row_sel(row_sel), .row_bits(row_bits), .player_col(player_col),
        .score(score), .state(state)
    );

    falling_object_engine #(.ROWS(32), .TICK_DIV(4)) u_dut2 (
        .clk(clk), .rst(rst2), .left_btn(1'b0), .right_btn(1'b0),
        .function_btn(fn2), .spawn_req(spawn2), .rand_col(rand_col2),
        .row_sel(row_sel2), .row_bits(row_bits2), .player_col(player_col2),
        .score(score2), .state(state2)
    );

    typedef struct {
        logic       l;
        logic       r;
        int         n;
        logic [4:0] exp_col;
    } mv_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ps1    = 0;
    int ps2    = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance to the edge that commits the next game tick
    task automatic next_tick(input int start, input int div);
        step();
        while (((cyc - start) % div) != 0) step();
    endtask

    task automatic ticks(input int start, input int div, input int n);
        for (int i = 0; i < n; i++) next_tick(start, div);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [3:0] r, input logic [31:0] exp);
        row_sel = r;
        step();
        chk(name, row_bits, exp);
    endtask

    task automatic chk_row2(input string name, input logic [4:0] r, input logic [31:0] exp);
        row_sel2 = r;
        step();
        chk(name, row_bits2, exp);
    endtask

    mv_t mv [8];

    initial begin
        mv[0] = '{l: 1'b0, r: 1'b1, n: 1,  exp_col: 5'd14};
        mv[1] = '{l: 1'b0, r: 1'b1, n: 29, exp_col: 5'd27};
        mv[2] = '{l: 1'b1, r: 1'b0, n: 1,  exp_col: 5'd26};
        mv[3] = '{l: 1'b1, r: 1'b0, n: 29, exp_col: 5'd0};
        mv[4] = '{l: 1'b1, r: 1'b1, n: 3,  exp_col: 5'd0};
        mv[5] = '{l: 1'b0, r: 1'b1, n: 1,  exp_col: 5'd1};
        mv[6] = '{l: 1'b1, r: 1'b1, n: 2,  exp_col: 5'd1};
        mv[7] = '{l: 1'b0, r: 1'b0, n: 2,  exp_col: 5'd1};

        rst = 1'b1; left_btn = 1'b0; right_btn = 1'b0; function_btn = 1'b0;
        spawn_req = 1'b0; rand_col = 5'd0; row_sel = 4'd0;
        rst2 = 1'b1; fn2 = 1'b0; spawn2 = 1'b0; rand_col2 = 5'd0; row_sel2 = 5'd0;
        steps(2);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_score", 32'(score), 32'd0);
        chk("reset_player", 32'(player_col), 32'd13);
        chk("reset_rows", row_bits, 32'h0);
        rst = 1'b0; rst2 = 1'b0;
        step();
        chk("idle_rows", row_bits, 32'hFFFF_FFFF);
        chk("idle_state", 32'(state), 32'd0);

        // Start game; a held button must not retrigger
        function_btn = 1'b1;
        step();
        ps1 = cyc;
        chk("start_play", 32'(state), 32'd1);
        chk("start_player", 32'(player_col), 32'd13);
        steps(3);
        chk("held_btn_play", 32'(state), 32'd1);
        function_btn = 1'b0;

        // One object at column 2 falls the full height and scores
        spawn_req = 1'b1; rand_col = 5'd2;
        next_tick(ps1, 250);
        spawn_req = 1'b0;
        chk_row("spawn_row0", 4'd0, 32'h0000_0004);
        chk_row("player_row", 4'd15, 32'h0003_E000);
        ticks(ps1, 250, 15);
        chk_row("obj_bottom", 4'd15, 32'h0003_E004);
        chk("score_before_free", 32'(score), 32'd0);
        next_tick(ps1, 250);
        chk("score_after_free", 32'(score), 32'd1);
        chk_row("freed_row", 4'd15, 32'h0003_E000);
        chk("still_play", 32'(state), 32'd1);

        // Player movement table
        for (int k = 0; k < 8; k++) begin
            left_btn  = mv[k].l;
            right_btn = mv[k].r;
            ticks(ps1, 250, mv[k].n);
            chk($sformatf("move_%0d", k), 32'(player_col), 32'(mv[k].exp_col));
        end
        left_btn = 1'b0; right_btn = 1'b0;
        chk_row("player_at_1", 4'd15, 32'h0000_003E);

        // Collision: objects dropped straight onto the player
        rst = 1'b1;
        step();
        rst = 1'b0;
        function_btn = 1'b1;
        step();
        ps1 = cyc;
        chk("restart_play", 32'(state), 32'd1);
        function_btn = 1'b0;
        spawn_req = 1'b1; rand_col = 5'd15;
        ticks(ps1, 250, 16);
        chk("pre_collision", 32'(state), 32'd1);
        step();
        chk("collision_over", 32'(state), 32'd2);
        chk("collision_score", 32'(score), 32'd0);
        right_btn = 1'b1;
        steps(300);
        chk("over_player", 32'(player_col), 32'd13);
        chk("over_score", 32'(score), 32'd0);
        chk("over_state", 32'(state), 32'd2);
        chk_row("over_row14", 4'd14, 32'h0000_8000);
        chk_row("over_row0", 4'd0, 32'h0000_8000);
        right_btn = 1'b0; spawn_req = 1'b0;
        function_btn = 1'b1;
        step();
        chk("over_to_idle", 32'(state), 32'd0);
        function_btn = 1'b0;
        step();
        chk("over_idle_rows", row_bits, 32'hFFFF_FFFF);

        // New game clears the pool; build score 3 with 5 live objects then reset
        function_btn = 1'b1;
        step();
        ps1 = cyc;
        chk("play_again", 32'(state), 32'd1);
        function_btn = 1'b0;
        chk_row("pool_cleared", 4'd14, 32'h0);
        spawn_req = 1'b1; rand_col = 5'd0;
        ticks(ps1, 250, 3);
        spawn_req = 1'b0;
        ticks(ps1, 250, 11);
        spawn_req = 1'b1;
        ticks(ps1, 250, 5);
        spawn_req = 1'b0;
        chk("score_three", 32'(score), 32'd3);
        chk_row("live_row0", 4'd0, 32'h0000_0001);
        chk_row("live_row4", 4'd4, 32'h0000_0001);
        steps(100);
        rst = 1'b1; function_btn = 1'b1; spawn_req = 1'b1; right_btn = 1'b1;
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_rows", row_bits, 32'h0);
        chk("rst_player", 32'(player_col), 32'd13);
        rst = 1'b0; function_btn = 1'b0; spawn_req = 1'b0; right_btn = 1'b0;
        step();
        chk("rst_idle_rows", row_bits, 32'hFFFF_FFFF);
        chk("rst_idle_state", 32'(state), 32'd0);

        // Pool exhaustion on the 32-row instance
        fn2 = 1'b1;
        step();
        ps2 = cyc;
        chk("dut2_play", 32'(state2), 32'd1);
        fn2 = 1'b0;
        spawn2 = 1'b1; rand_col2 = 5'd0;
        ticks(ps2, 4, 20);
        chk_row2("pool_20", 5'd0, 32'h0000_0001);
        next_tick(ps2, 4);
        chk_row2("pool_drop", 5'd0, 32'h0);
        chk_row2("pool_row20", 5'd20, 32'h0000_0001);
        ticks(ps2, 4, 11);
        chk_row2("pool_still_full", 5'd0, 32'h0);
        chk_row2("pool_bottom", 5'd31, 32'h0003_E001);
        chk("pool_score0", 32'(score2), 32'd0);
        next_tick(ps2, 4);
        chk("pool_score1", 32'(score2), 32'd1);
        chk_row2("pool_refill", 5'd0, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/falling_object_engine.md
FALLING_OBJECT_ENGINE -- requirements
Module: falling_object_engine

Interface
REQ-001 Parameter N_OBJ, default 20, number of object slots in the pool.
REQ-002 Parameter COLS, default 32, playfield width in columns; COL_W = clog2(COLS).
REQ-003 Parameter ROWS, default 16, playfield height in rows; ROW_W = clog2(ROWS).
REQ-004 Parameter PW, default 5, player sprite width in columns.
REQ-005 Parameter TICK_DIV, default 250, clk cycles per game tick.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 left_btn / right_btn  input  1 each  level move requests.
REQ-009 function_btn  input  1  start/acknowledge button, level.
REQ-010 spawn_req  input  1  sampled at tick: request one new object.
REQ-011 rand_col  input  COL_W  spawn column, sampled at tick.
REQ-012 row_sel  input  ROW_W  display row query.
REQ-013 row_bits  output  COLS  registered pixel row for row_sel.
REQ-014 player_col  output  COL_W  leftmost player column.
REQ-015 score  output  16  objects survived.
REQ-016 state  output  2  FSM state: IDLE=0, PLAY=1, OVER=2.

Function
REQ-017 FSM: IDLE -> PLAY on function_btn rising edge (one-cycle edge detector); PLAY -> OVER on collision; OVER -> IDLE on function_btn rising edge; code 3 unreachable, decodes to IDLE next cycle.
REQ-018 IDLE->PLAY: all slots freed, score=0, tick counter=0, player_col=(COLS-PW)/2.
REQ-019 Tick counter runs only in PLAY, counts 0..TICK_DIV-1; tick fires in the cycle counter==TICK_DIV-1, counter then wraps to 0.
REQ-020 Slot holds valid, col (COL_W), y (ROW_W); y=0 is the top row.
REQ-021 On tick, step 1: right_btn only -> player_col+1 if < COLS-PW; left_btn only -> player_col-1 if > 0; both or neither -> no move.
REQ-022 On tick, step 2: every valid slot with y==ROWS-1 freed and score incremented once per freed slot (multiple same tick summed), saturating at 0xFFFF; other valid slots y+1.
REQ-023 On tick, step 3: if spawn_req, lowest-index slot free after step 2 loaded valid=1, y=0, col=min(rand_col, COLS-1); pool full -> request silently dropped.
REQ-024 All three steps commit in the same clk edge; at most one spawn per tick.
REQ-025 Collision: in PLAY, any valid slot with y==ROWS-1 and player_col <= col <= player_col+PW-1 -> state=OVER next cycle; that slot neither freed nor scored.
REQ-026 OVER: slots, player_col, score frozen; buttons and spawn_req ignored.
REQ-027 row_bits one-cycle latency from row_sel: IDLE -> all ones; PLAY/OVER -> bit c set if any valid slot has y==row_sel and col==c, OR row_sel==ROWS-1 and c within player span.
REQ-028 Collision check uses registered state only; no combinational path from inputs to outputs.

Reset
REQ-029 rst in any state, including mid-tick: state=IDLE, all slots invalid, score=0, tick counter=0, player_col=(COLS-PW)/2, row_bits=0, edge-detector history=0.
REQ-030 rst has priority over every other input in the same cycle.

Verification
REQ-031 Defaults, rst then function_btn pulse -> state=1 next cycle, player_col=13; function_btn held high gives no second transition.
REQ-032 PLAY, spawn_req=1 rand_col=2 for one tick, player at 13 -> object at y=0 col=2, reaches y=15 after 15 further ticks, freed next tick, score=1.
REQ-033 spawn_req=1 rand_col=15 each tick, player_col=13 -> OVER one cycle after first object reaches y=15; score stays 0.
REQ-034 spawn_req=1 every tick with ROWS=32 -> 20 slots fill, 21st request dropped, valid count stays 20 until first slot frees.
REQ-035 right_btn held 30 ticks from 13 -> player_col saturates at 27; left_btn held 30 ticks -> 0; both held -> unchanged.
REQ-036 rst asserted mid-PLAY with 5 live objects and score=3 -> next cycle state=0, score=0, row_bits=0 then all ones in IDLE.
